ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 6, meaning RAM address width.
REQ-002 The block SHALL have parameter DW, default 16, meaning RAM data width.
REQ-003 The block SHALL have parameter RD_LAT, default 2, meaning RAM read latency in cycles from command to valid ram_do (range 1-4).
REQ-004 The block SHALL have port CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port RST_n  input  1  reset; asynchronous, active-low.
REQ-006 The block SHALL have ports reqA/reqB  input  1 each  requester access request.
REQ-007 The block SHALL have ports weA/weB  input  1 each  1 = write, 0 = read.
REQ-008 The block SHALL have ports addrA/addrB  input  AW each  access address.
REQ-009 The block SHALL have ports dinA/dinB  input  DW each  write data.
REQ-010 The block SHALL have ports gntA/gntB  output  1 each  grant; the request is accepted in a cycle when req and gnt are both high.
REQ-011 The block SHALL have ports rvalidA/rvalidB  output  1 each  one-cycle read-data-valid pulse.
REQ-012 The block SHALL have ports rdataA/rdataB  output  DW each  read data, qualified by rvalid.
REQ-013 The block SHALL have port ram_we  output  1  RAM write enable.
REQ-014 The block SHALL have port ram_addr  output  AW  RAM address.
REQ-015 The block SHALL have port ram_di  output  DW  RAM write data.
REQ-016 The block SHALL have port ram_oe  output  1  RAM output-register enable.
REQ-017 The block SHALL have port ram_do  input  DW  RAM read data.

Function
REQ-018 gntA/gntB SHALL be combinational from reqA/reqB and the priority pointer, with at most one high per cycle.
REQ-019 With exactly one requester high, that requester SHALL be granted.
REQ-020 With both high, the requester not granted most recently SHALL be granted (round-robin); the pointer SHALL update only on an accepted request.
REQ-021 With neither high, no grant SHALL assert and the pointer SHALL hold.
REQ-022 An accepted request SHALL be registered onto ram_we/ram_addr/ram_di on the next rising edge (the command cycle); ram_we SHALL be high only in command cycles of writes.
REQ-023 In idle cycles ram_we SHALL be 0; ram_addr and ram_di SHALL hold their last values.
REQ-024 ram_oe SHALL be 1 at all times out of reset.
REQ-025 Each command cycle SHALL push a tag {valid = read, owner = A/B} into an RD_LAT-deep shift pipeline; idle and write cycles SHALL push valid = 0.
REQ-026 When a tag with valid = 1 exits the pipeline, ram_do SHALL be registered into the owner's rdata and that owner's rvalid SHALL pulse for one cycle.
REQ-027 Read latency from the accept edge to rvalid high SHALL be exactly RD_LAT+2 cycles (4 at the default).
REQ-028 Both requesters MAY be served back-to-back; throughput SHALL be one access per cycle with no bubbles.
REQ-029 Responses SHALL return in issue order, and the non-owner's rvalid SHALL stay 0.
REQ-030 A write followed by a read of the same address in the next accepted cycle SHALL return the newly written data.
REQ-031 rdataX SHALL hold its value between rvalidX pulses.
REQ-032 Writes SHALL produce no rvalid.

Reset
REQ-033 While RST_n = 0, gntA, gntB, rvalidA, rvalidB, ram_we and ram_oe SHALL be 0; ram_addr, ram_di, rdataA and rdataB SHALL be 0; all tags SHALL be invalid; the pointer SHALL make A the winner of the first contention.
REQ-034 Reset asserted mid-operation SHALL discard every in-flight read: no rvalid after RST_n rises, and no RAM write for a request accepted in the reset cycle.
REQ-035 The block SHALL be fully operational in the first cycle after RST_n rises.

Verification
REQ-036 Both requesters read continuously for 6 cycles -> grants alternate A,B,A,B,A,B; rvalid pulses alternate with the same order, each 4 cycles after its accept.
REQ-037 A writes 16'hBEEF to addr 5, then A reads addr 5 in the next cycle -> rvalidA with rdataA = 16'hBEEF, and rvalidB stays 0.
REQ-038 Only B requests, 10 consecutive reads of addr 0-9 -> gntB held high and 10 back-to-back rvalidB pulses with data in address order.
REQ-039 B reads addr 3, then RST_n is pulled low one cycle later for 2 cycles -> no rvalidB ever appears, all outputs are 0 during reset, and the first contention after reset is granted to A.
REQ-040 Interleaved write by A and read by B to the same addr 7 in consecutive cycles (A first) -> B receives A's data; issuing in the reverse order gives B the old data.
REQ-041 RD_LAT = 1 and 4 builds, single read -> rvalid 3 and 6 cycles after accept respectively.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Read responses are steered back to their owner by a tag pipeline.
module ram_port_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          reqA,
    input  logic          reqB,
    input  logic          weA,
    input  logic          weB,
    input  logic [AW-1:0] addrA,
    input  logic [AW-1:0] addrB,
    input  logic [DW-1:0] dinA,
    input  logic [DW-1:0] dinB,
    output logic          gntA,
    output logic          gntB,
    output logic          rvalidA,
    output logic          rvalidB,
    output logic [DW-1:0] rdataA,
    output logic [DW-1:0] rdataB,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    output logic          ram_oe,
    input  logic [DW-1:0] ram_do
);

    logic              r_prio;
    logic              r_we;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_di;
    logic              r_cmd_v;
    logic              r_cmd_b;
    logic [RD_LAT-1:0] r_tag_v;
    logic [RD_LAT-1:0] r_tag_b;
    logic              r_rvalidA;
    logic              r_rvalidB;
    logic [DW-1:0]     r_rdataA;
    logic [DW-1:0]     r_rdataB;

    logic              w_gntA;
    logic              w_gntB;
    logic              w_acc;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_din;
    logic              w_outA;
    logic              w_outB;

    // r_prio = 1 means B wins the next contention.
    // Grants are gated by reset so nothing is accepted while it is low.
    assign w_gntA = RST_n & reqA & (~reqB | ~r_prio);
    assign w_gntB = RST_n & reqB & (~reqA | r_prio);
    assign w_acc  = w_gntA | w_gntB;
    assign w_we   = w_gntA ? weA   : weB;
    assign w_addr = w_gntA ? addrA : addrB;
    assign w_din  = w_gntA ? dinA  : dinB;

    assign w_outA = r_tag_v[RD_LAT-1] & ~r_tag_b[RD_LAT-1];
    assign w_outB = r_tag_v[RD_LAT-1] &  r_tag_b[RD_LAT-1];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_prio    <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_di      <= '0;
            r_cmd_v   <= 1'b0;
            r_cmd_b   <= 1'b0;
            r_tag_v   <= '0;
            r_tag_b   <= '0;
            r_rvalidA <= 1'b0;
            r_rvalidB <= 1'b0;
            r_rdataA  <= '0;
            r_rdataB  <= '0;
        end else begin
            if (w_acc) begin
                r_prio <= w_gntA;
                r_addr <= w_addr;
                r_di   <= w_din;
            end
            r_we    <= w_acc & w_we;
            r_cmd_v <= w_acc & ~w_we;
            r_cmd_b <= w_gntB;
            r_tag_v[0] <= r_cmd_v;
            r_tag_b[0] <= r_cmd_b;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_b[i] <= r_tag_b[i-1];
            end
            r_rvalidA <= w_outA;
            r_rvalidB <= w_outB;
            if (w_outA) r_rdataA <= ram_do;
            if (w_outB) r_rdataB <= ram_do;
        end
    end

    assign gntA     = w_gntA;
    assign gntB     = w_gntB;
    assign rvalidA  = r_rvalidA;
    assign rvalidB  = r_rvalidB;
    assign rdataA   = r_rdataA;
    assign rdataB   = r_rdataB;
    assign ram_we   = r_we;
    assign ram_addr = r_addr;
    assign ram_di   = r_di;
    assign ram_oe   = RST_n;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three builds (RD_LAT 2,1,4) on shared stimulus,
// each with its own RAM model; build 0 is scoreboarded every cycle.
module tb_ram_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int LAT0 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic reqA = 1'b0, reqB = 1'b0, weA = 1'b0, weB = 1'b0;
    logic [AW-1:0] addrA = '0, addrB = '0;
    logic [DW-1:0] dinA = '0, dinB = '0;

    logic gntA [3], gntB [3], rvalidA [3], rvalidB [3];
    logic ram_we [3], ram_oe [3];
    logic [AW-1:0] ram_addr [3];
    logic [DW-1:0] ram_di [3], rdataA [3], rdataB [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic b;
        logic [DW-1:0] d;
        int due;
    } exp_t;
    exp_t sb [$];
    exp_t mon_e;

    logic [DW-1:0] shadow [64];
    logic m_prio = 1'b0;
    logic m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_di = '0;
    logic [DW-1:0] last_a = '0, last_b = '0, mon_d;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? LAT0 : (g == 1) ? 1 : 4;
        logic [DW-1:0] mem [64];
        logic [DW-1:0] pipe [L];

        ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(L)) u_dut (
            .CLK(clk), .RST_n(rst_n),
            .reqA(reqA), .reqB(reqB), .weA(weA), .weB(weB),
            .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
            .gntA(gntA[g]), .gntB(gntB[g]),
            .rvalidA(rvalidA[g]), .rvalidB(rvalidB[g]),
            .rdataA(rdataA[g]), .rdataB(rdataB[g]),
            .ram_we(ram_we[g]), .ram_addr(ram_addr[g]), .ram_di(ram_di[g]),
            .ram_oe(ram_oe[g]), .ram_do(pipe[L-1])
        );

        initial for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);

        always @(posedge clk) begin
            if (ram_we[g]) mem[ram_addr[g]] <= ram_di[g];
            if (ram_oe[g]) begin
                pipe[0] <= mem[ram_addr[g]];
                for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
            end
        end
    end

    // Response scoreboard for build 0.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_a = '0;
            last_b = '0;
        end else begin
            if (rvalidA[0] || rvalidB[0]) begin
                checks++;
                if (rvalidA[0] && rvalidB[0]) begin
                    errors++;
                    $display("FAIL rvalid_both cyc=%0d got A=1 B=1 expected one", cyc);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected cyc=%0d got A=%b B=%b expected none",
                             cyc, rvalidA[0], rvalidB[0]);
                end else begin
                    mon_e = sb.pop_front();
                    mon_d = rvalidB[0] ? rdataB[0] : rdataA[0];
                    if (rvalidB[0] !== mon_e.b || mon_d !== mon_e.d || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL rresp got ownerB=%b data=%h cyc=%0d expected ownerB=%b data=%h cyc=%0d",
                                 rvalidB[0], mon_d, cyc, mon_e.b, mon_e.d, mon_e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                mon_e = sb.pop_front();
                $display("FAIL rresp_missing cyc=%0d expected ownerB=%b data=%h at cyc=%0d",
                         cyc, mon_e.b, mon_e.d, mon_e.due);
            end
            checks++;
            if ((!rvalidA[0] && rdataA[0] !== last_a) ||
                (!rvalidB[0] && rdataB[0] !== last_b)) begin
                errors++;
                $display("FAIL rdata_hold cyc=%0d got A=%h B=%h expected A=%h B=%h",
                         cyc, rdataA[0], rdataB[0], last_a, last_b);
            end
            if (rvalidA[0]) last_a = rdataA[0];
            if (rvalidB[0]) last_b = rdataB[0];
        end
    end

    // One cycle of stimulus: checks grants against the model, then the
    // RAM command registered on the following edge.
    task automatic drive(input logic ra, input logic wa, input logic [AW-1:0] aa,
                         input logic [DW-1:0] da, input logic rb, input logic wb,
                         input logic [AW-1:0] ab, input logic [DW-1:0] db);
        logic egA, egB, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        reqA = ra; weA = wa; addrA = aa; dinA = da;
        reqB = rb; weB = wb; addrB = ab; dinB = db;
        @(negedge clk);
        egA = ra && (!rb || !m_prio);
        egB = rb && (!ra || m_prio);
        checks++;
        if (gntA[0] !== egA || gntB[0] !== egB) begin
            errors++;
            $display("FAIL grant cyc=%0d got A=%b B=%b expected A=%b B=%b",
                     cyc, gntA[0], gntB[0], egA, egB);
        end
        m_we = 1'b0;
        if (egA || egB) begin
            w = egA ? wa : wb;
            a = egA ? aa : ab;
            d = egA ? da : db;
            if (w) shadow[a] = d;
            else sb.push_back('{b: egB, d: shadow[a], due: cyc + LAT0 + 2});
            m_prio = egA;
            m_we = w;
            m_addr = a;
            m_di = d;
        end
        @(posedge clk);
        #1;
        checks++;
        if (ram_we[0] !== m_we || ram_addr[0] !== m_addr || ram_di[0] !== m_di) begin
            errors++;
            $display("FAIL ram_cmd cyc=%0d got we=%b addr=%h di=%h expected we=%b addr=%h di=%h",
                     cyc, ram_we[0], ram_addr[0], ram_di[0], m_we, m_addr, m_di);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        checks++;
        if ({gntA[0], gntB[0], rvalidA[0], rvalidB[0], ram_we[0], ram_oe[0],
             ram_addr[0], ram_di[0], rdataA[0], rdataB[0]} !== '0) begin
            errors++;
            $display("FAIL %s got gnt=%b%b rv=%b%b we=%b oe=%b addr=%h di=%h rdA=%h rdB=%h expected all 0",
                     tag, gntA[0], gntB[0], rvalidA[0], rvalidB[0], ram_we[0], ram_oe[0],
                     ram_addr[0], ram_di[0], rdataA[0], rdataB[0]);
        end
    endtask

    task automatic test_reset;
        reqA = 1; reqB = 1; weA = 1; weB = 1; addrA = 6'h11; dinA = 16'h5555;
        check_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1;
        reqA = 0; reqB = 0; weA = 0; weB = 0;
        @(negedge clk);
        checks++;
        if (ram_oe[0] !== 1'b1 || ram_we[0] !== 1'b0) begin
            errors++;
            $display("FAIL oe_after_reset got oe=%b we=%b expected oe=1 we=0", ram_oe[0], ram_we[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < 6; i++) drive(1, 0, 6'(20 + i), 0, 1, 0, 6'(40 + i), 0);
        idle(8);
    endtask

    task automatic test_write_then_read;
        drive(1, 1, 5, 16'hBEEF, 0, 0, 0, 0);
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        idle(8);
    endtask

    task automatic test_b_stream;
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1, 0, 6'(i), 0);
        idle(8);
    endtask

    task automatic test_forwarding;
        drive(1, 1, 7, 16'h1234, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 7, 0);
        drive(0, 0, 0, 0, 1, 0, 7, 0);
        drive(1, 1, 7, 16'h5678, 0, 0, 0, 0);
        idle(8);
    endtask

    task automatic test_reset_mid;
        drive(0, 0, 0, 0, 1, 0, 3, 0);
        drive(1, 0, 9, 0, 0, 0, 0, 0);
        rst_n = 0;
        reqA = 1; reqB = 1; weA = 1; weB = 1; addrA = 6'h2A; dinA = 16'hDEAD;
        sb.delete();
        m_prio = 0; m_we = 0; m_addr = '0; m_di = '0;
        check_zero("reset_mid_1");
        check_zero("reset_mid_2");
        @(posedge clk);
        #1;
        rst_n = 1;
        reqA = 0; reqB = 0; weA = 0; weB = 0;
        idle(8);
        drive(1, 0, 4, 0, 1, 0, 6, 0);
        drive(1, 0, 4, 0, 1, 0, 6, 0);
        idle(8);
    endtask

    task automatic test_latency;
        int n, t1, t4;
        logic [DW-1:0] d1, d4;
        t1 = -1; t4 = -1; d1 = '0; d4 = '0;
        drive(1, 0, 12, 0, 0, 0, 0, 0);
        n = cyc - 1;
        reqA = 0;
        repeat (10) begin
            @(negedge clk);
            if (rvalidA[1] && t1 < 0) begin t1 = cyc; d1 = rdataA[1]; end
            if (rvalidA[2] && t4 < 0) begin t4 = cyc; d4 = rdataA[2]; end
        end
        checks++;
        if (t1 != n + 3 || d1 !== shadow[12]) begin
            errors++;
            $display("FAIL lat1 got cyc=%0d data=%h expected cyc=%0d data=%h", t1, d1, n + 3, shadow[12]);
        end
        checks++;
        if (t4 != n + 6 || d4 !== shadow[12]) begin
            errors++;
            $display("FAIL lat4 got cyc=%0d data=%h expected cyc=%0d data=%h", t4, d4, n + 6, shadow[12]);
        end
        @(posedge clk);
        #1;
        idle(4);
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)),
                  16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 15)), 16'($urandom));
        idle(10);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = 16'hA000 + 16'(i);
        test_reset();
        test_round_robin();
        test_write_then_read();
        test_b_stream();
        test_forwarding();
        test_reset_mid();
        test_latency();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
